// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 slave sequencer: oversamples cs/sclk/mosi in sys_clk,
// deframes command/data bytes and drives a small register-file port.
module spi_slave_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 3
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              frame_err
);

  typedef enum logic [2:0] {
    WAIT_DESEL, IDLE, CMD, WR_DATA, RD_DATA
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   cs_dly_q, sclk_dly_q;

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_wdata_q, reg_wdata_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_re_q, reg_re_d;
  logic              re_dly_q, re_dly_d;
  logic              inc_pend_q, inc_pend_d;
  logic              frame_err_q, frame_err_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;

  logic       cs_s, sclk_s, mosi_s;
  logic       cs_rise, cs_fall, sclk_rise, sclk_fall;
  logic       byte_done;
  logic [7:0] rx_byte;

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_rise   = cs_s & ~cs_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign rx_byte   = {rx_q[6:0], mosi_s};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    re_dly_d    = reg_re_q;
    inc_pend_d  = 1'b0;
    frame_err_d = 1'b0;

    // Address advances the cycle after a byte; reads prefetch right after.
    if (inc_pend_q) begin
      addr_d = addr_q + ADDR_ONE;
      if (state_q == RD_DATA) begin
        reg_re_d   = 1'b1;
        reg_addr_d = addr_q + ADDR_ONE;
      end
    end

    unique case (state_q)
      WAIT_DESEL: begin
        if (cs_s) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          state_d   = CMD;
          bit_cnt_d = 3'd0;
          rx_d      = 8'h00;
          tx_d      = 8'h00;
        end
      end
      CMD, WR_DATA, RD_DATA: begin
        if (sclk_rise) begin
          rx_d      = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (state_q == RD_DATA && sclk_fall && bit_cnt_q != 3'd0)
          tx_d = {tx_q[6:0], 1'b0};
        if (byte_done) begin
          if (state_q == CMD) begin
            addr_d = rx_byte[ADDR_W-1:0];
            if (rx_byte[7]) begin
              state_d    = RD_DATA;
              reg_re_d   = 1'b1;
              reg_addr_d = rx_byte[ADDR_W-1:0];
            end else begin
              state_d = WR_DATA;
            end
          end else if (state_q == WR_DATA) begin
            reg_we_d    = 1'b1;
            reg_addr_d  = addr_q;
            reg_wdata_d = rx_byte;
            inc_pend_d  = 1'b1;
          end else begin
            inc_pend_d = 1'b1;
          end
        end
        // A byte finishing on the deselect edge still counts as complete.
        if (cs_rise) begin
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
          if (bit_cnt_q != 3'd0 && !byte_done) frame_err_d = 1'b1;
        end
      end
      default: state_d = WAIT_DESEL;
    endcase

    if (re_dly_q) tx_d = reg_rdata;

    oe_d   = (state_d == CMD) || (state_d == WR_DATA) ||
             (state_d == RD_DATA);
    busy_d = oe_d;
    miso_d = (state_d == RD_DATA) && tx_d[7];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_dly_q    <= 1'b0;
      sclk_dly_q  <= 1'b0;
      state_q     <= WAIT_DESEL;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      addr_q      <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      re_dly_q    <= 1'b0;
      inc_pend_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_dly_q    <= cs_s;
      sclk_dly_q  <= sclk_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      re_dly_q    <= re_dly_d;
      inc_pend_q  <= inc_pend_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign reg_we      = reg_we_q;
  assign reg_re      = reg_re_q;
  assign busy        = busy_q;
  assign frame_err   = frame_err_q;

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
- Sequences the SPI slave datapath on the TinyFPGA A2 pins (cs, sclk, mosi, miso).
- Oversamples the SPI pins in the system clock domain, deframes command/data bytes and drives a small register-file port.
- Controls the MISO output enable so the pad is tristated whenever the slave is not selected.
- SPI mode 0 only; SCLK must not exceed sys_clk/8.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on cs/sclk/mosi (minimum 2).
- ADDR_W, 3, register address width; the register count is 2**ADDR_W.

Ports:
- sys_clk  in  1  system clock; all logic runs on its rising edge.
- sys_rst  in  1  reset, synchronous, active-high.
- spi_cs_n  in  1  chip select from pin18_cs, active low, asynchronous to sys_clk.
- spi_sclk  in  1  SPI clock from pin19_sclk, asynchronous.
- spi_mosi  in  1  serial data in from pin4_mosi, asynchronous.
- spi_miso  out  1  serial data out to pin20_miso.
- spi_miso_oe  out  1  pad output enable for pin20_miso; 1 = drive.
- reg_addr  out  ADDR_W  register address.
- reg_wdata  out  8  register write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  8  read data, valid exactly 1 cycle after reg_re.
- busy  out  1  high while a transaction is in progress (state other than IDLE/WAIT_DESEL).
- frame_err  out  1  one-cycle pulse when cs deasserts mid-byte.

Behaviour:
- Clock and reset: one clock (sys_clk); reset sys_rst is synchronous and active-high.
- Reset values: all outputs 0 (spi_miso_oe=0, spi_miso=0, reg_* = 0, busy=0, frame_err=0). Internal state = WAIT_DESEL, bit counter = 0, shift registers = 0.
- Synchronisation: each pin passes through SYNC_STAGES flops, then one edge-detect flop.
  - sclk_rise = s & ~s_d; sclk_fall = ~s & s_d; cs_fall/cs_rise are defined the same way.
  - Pin-to-event latency is SYNC_STAGES+1 cycles.
- States:
  - WAIT_DESEL: go to IDLE when synced cs_n=1. This state is entered after reset, so a transaction already in flight when reset releases is ignored.
  - IDLE: on cs_fall go to CMD; clear the bit counter.
  - CMD: on each sclk_rise, shift mosi into rx (MSB first) and increment bit_cnt mod 8. When the 8th bit arrives:
    - addr <= rx[ADDR_W-1:0].
    - If rx[7]=1: go to RD_DATA and pulse reg_re with that address.
    - Otherwise go to WR_DATA.
    - rx[6:ADDR_W] is ignored.
  - WR_DATA: on completion of each 8-bit byte, pulse reg_we for one cycle with reg_addr=addr and reg_wdata=byte. On the next cycle, addr <= addr+1 mod 2**ADDR_W.
  - RD_DATA:
    - One cycle after each reg_re, tx <= reg_rdata.
    - spi_miso = tx[7].
    - On sclk_fall with bit_cnt != 0, tx shifts left with 0 fill. A sclk_fall with bit_cnt == 0 (byte boundary) does not shift.
    - On completion of each byte: addr <= addr+1 mod 2**ADDR_W, then pulse reg_re for the new address (prefetch) the following cycle.
    - mosi bits are shifted but discarded.
- Any state except WAIT_DESEL/IDLE on cs_rise:
  - Go to IDLE.
  - If bit_cnt != 0, pulse frame_err. The partial byte is discarded and no reg_we is issued.
  - A completed byte's reg_we is never suppressed.
- spi_miso_oe = 1 in CMD, WR_DATA and RD_DATA; 0 otherwise. spi_miso = 0 whenever not in RD_DATA.
- Simultaneous cs_rise and 8th sclk_rise in the same cycle: the byte counts as complete (write issued), then go to IDLE, with no frame_err.
- Reset mid-transaction: abort immediately with no strobes, then go to WAIT_DESEL.
- Timing: with SCLK ≤ sys_clk/8, tx is reloaded ≥1 cycle before the first falling edge of the next byte.

Test Plan:
- Write burst: cs low, send 0x02, 0xA5, 0x3C, cs high -> reg_we pulses (addr 2, data 0xA5) then (addr 3, data 0x3C); exactly 2 pulses; frame_err stays 0.
- Read burst: model regs[5]=0x81, regs[6]=0x7E; send 0x85 then two dummy bytes -> MISO returns 0x81 then 0x7E MSB-first, sampled on sclk rising; reg_re seen for addr 5, 6, 7.
- Address wrap: write 0x07, 0x11, 0x22 -> writes to addr 7 then addr 0.
- Mid-byte abort: send 0x01, then 5 bits, cs high -> one frame_err pulse, no reg_we; next transaction 0x01, 0x55 writes addr 1 = 0x55.
- Reset in flight: assert sys_rst for 1 cycle during the data byte of a write, cs kept low -> no reg_we; spi_miso_oe=0 and stays 0 until cs goes high and low again.
- Tristate: cs high idle -> spi_miso_oe=0; spi_miso_oe=1 within SYNC_STAGES+2 cycles of cs falling.
